// File: rtl/random_generator.sv
// Purpose : maximal-length Galois LFSR pseudo-random source, WIDTH-bit state.
// Latency : seed visible one edge after reset=1; first new value on first edge after release.
// Backpressure: none; free-running, advances one step every clock when not in reset.
//
// Ports:
//   clk     - rising-edge clock for all state updates
//   reset   - synchronous active-high reset; loads seed (0 is replaced by 1)
//   seed    - initial LFSR state, sampled only while reset=1
//   dataOut - current LFSR state, driven straight from the state register
module random_generator #(
  parameter int          WIDTH = 8,
  parameter logic [31:0] TAPS  = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] dataOut
);

  // Right-shift Galois masks: bit (t-1) set for each polynomial tap t.
  // Every entry gives period 2^w-1. Widths outside 3..32 return 0 and are
  // rejected below when no explicit mask is supplied.
  function automatic logic [31:0] table_mask(input int w);
    logic [31:0] m;
    case (w)
      3:       m = 32'h0000_0006;  // x^3+x^2+1
      4:       m = 32'h0000_000C;  // x^4+x^3+1
      5:       m = 32'h0000_0014;  // x^5+x^3+1
      6:       m = 32'h0000_0030;  // x^6+x^5+1
      7:       m = 32'h0000_0060;  // x^7+x^6+1
      8:       m = 32'h0000_00B8;  // x^8+x^6+x^5+x^4+1
      9:       m = 32'h0000_0110;  // x^9+x^5+1
      10:      m = 32'h0000_0240;  // x^10+x^7+1
      11:      m = 32'h0000_0500;  // x^11+x^9+1
      12:      m = 32'h0000_0E08;  // x^12+x^11+x^10+x^4+1
      13:      m = 32'h0000_1C80;  // x^13+x^12+x^11+x^8+1
      14:      m = 32'h0000_3802;  // x^14+x^13+x^12+x^2+1
      15:      m = 32'h0000_6000;  // x^15+x^14+1
      16:      m = 32'h0000_B400;  // x^16+x^14+x^13+x^11+1
      17:      m = 32'h0001_2000;  // x^17+x^14+1
      18:      m = 32'h0002_0400;  // x^18+x^11+1
      19:      m = 32'h0007_2000;  // x^19+x^18+x^17+x^14+1
      20:      m = 32'h0009_0000;  // x^20+x^17+1
      21:      m = 32'h0014_0000;  // x^21+x^19+1
      22:      m = 32'h0030_0000;  // x^22+x^21+1
      23:      m = 32'h0042_0000;  // x^23+x^18+1
      24:      m = 32'h00E1_0000;  // x^24+x^23+x^22+x^17+1
      25:      m = 32'h0120_0000;  // x^25+x^22+1
      26:      m = 32'h0200_0023;  // x^26+x^6+x^2+x+1
      27:      m = 32'h0400_0013;  // x^27+x^5+x^2+x+1
      28:      m = 32'h0900_0000;  // x^28+x^25+1
      29:      m = 32'h1400_0000;  // x^29+x^27+1
      30:      m = 32'h2000_0029;  // x^30+x^6+x^4+x+1
      31:      m = 32'h4800_0000;  // x^31+x^28+1
      32:      m = 32'h8020_0003;  // x^32+x^22+x^2+x+1
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  localparam logic [31:0]      MASK_SEL = (TAPS != 32'h0) ? TAPS : table_mask(WIDTH);
  localparam logic [WIDTH-1:0] MASK     = WIDTH'(MASK_SEL);

  generate
    if (TAPS == 32'h0 && (WIDTH < 3 || WIDTH > 32)) begin : g_bad_width
      $error("random_generator: WIDTH=%0d has no built-in mask (legal 3..32)", WIDTH);
    end
  endgenerate

  // No power-on value: the state is meaningless until the first reset edge.
  logic [WIDTH-1:0] s;

  always_ff @(posedge clk) begin
    if (reset) begin
      // An all-zero state would lock up, so a zero seed is replaced by 1.
      s <= (seed != '0) ? seed : WIDTH'(1);
    end else begin
      s <= (s >> 1) ^ (s[0] ? MASK : '0);
    end
  end

  assign dataOut = s;

endmodule

// File: tb/tb_random_generator.sv
module tb_random_generator;

  logic        clk = 1'b0;
  logic        reset8;
  logic [7:0]  seed8;
  logic [7:0]  data8;
  logic        reset16;
  logic [15:0] seed16;
  logic [15:0] data16;

  int errors = 0;
  int checks = 0;

  // Hand-computed sequence from seed 0x01 with mask 0xB8 (index = steps after release).
  logic [7:0] exp8 [0:10] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3,
                              8'hE1, 8'hC8, 8'h64, 8'h32, 8'h19};

  always #5 clk = ~clk;

  random_generator #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset8), .seed(seed8), .dataOut(data8)
  );

  random_generator #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset16), .seed(seed16), .dataOut(data16)
  );

  // Advance one rising edge; return 1 time unit later so outputs are stable
  // and inputs can be changed well clear of the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    seed8 = 8'h01; reset8 = 1'b1;
    tick();
    checks++;
    if (data8 !== 8'h01) begin
      errors++; $display("FAIL reset_load got=%h want=01", data8);
    end
    reset8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (data8 !== exp8[i]) begin
        errors++; $display("FAIL seq_step%0d got=%h want=%h", i, data8, exp8[i]);
      end
    end
  endtask

  task automatic test_zero_seed();
    seed8 = 8'h00; reset8 = 1'b1;
    tick();
    checks++;
    if (data8 !== 8'h01) begin
      errors++; $display("FAIL zero_seed_load got=%h want=01", data8);
    end
    reset8 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (data8 !== exp8[i]) begin
        errors++; $display("FAIL zero_seed_step%0d got=%h want=%h", i, data8, exp8[i]);
      end
    end
  endtask

  task automatic test_period();
    int seen [0:255];
    int bad;
    int first_one;
    for (int v = 0; v < 256; v++) seen[v] = 0;
    bad = 0;
    first_one = 0;
    seed8 = 8'h01; reset8 = 1'b1;
    tick();
    reset8 = 1'b0;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (^data8 === 1'bx) bad++;
      else seen[data8]++;
      if (data8 === 8'h01 && first_one == 0) first_one = k;
    end
    for (int v = 1; v < 256; v++) if (seen[v] != 1) bad++;
    checks++;
    if (seen[0] !== 0) begin
      errors++; $display("FAIL period_zero_seen got=%0d want=0", seen[0]);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL period_unique bad_values=%0d want=0", bad);
    end
    checks++;
    if (first_one !== 255) begin
      errors++; $display("FAIL period_return cycle=%0d want=255", first_one);
    end
    checks++;
    if (data8 !== 8'h01) begin
      errors++; $display("FAIL period_end got=%h want=01", data8);
    end
  endtask

  task automatic test_seed_ignored();
    seed8 = 8'h01; reset8 = 1'b1;
    tick();
    reset8 = 1'b0;
    for (int i = 1; i <= 10; i++) tick();
    checks++;
    if (data8 !== exp8[10]) begin
      errors++; $display("FAIL run10 got=%h want=%h", data8, exp8[10]);
    end
    seed8 = 8'h5A;
    tick();
    checks++;
    if (data8 !== 8'hB4) begin
      errors++; $display("FAIL seed_ignored1 got=%h want=b4", data8);
    end
    tick();
    checks++;
    if (data8 !== 8'h5A) begin
      errors++; $display("FAIL seed_ignored2 got=%h want=5a", data8);
    end
    seed8 = 8'h5A;
    reset8 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (data8 !== 8'h5A) begin
        errors++; $display("FAIL midreset_load%0d got=%h want=5a", i, data8);
      end
    end
    reset8 = 1'b0;
    tick();
    checks++;
    if (data8 !== 8'h2D) begin
      errors++; $display("FAIL midreset_step1 got=%h want=2d", data8);
    end
    tick();
    checks++;
    if (data8 !== 8'hAE) begin
      errors++; $display("FAIL midreset_step2 got=%h want=ae", data8);
    end
  endtask

  task automatic test_hold_reset();
    // Start from a non-seed state so a missed reload is visible.
    reset8 = 1'b0;
    tick();
    seed8 = 8'h01; reset8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (data8 !== 8'h01) begin
        errors++; $display("FAIL hold_reset%0d got=%h want=01", i, data8);
      end
    end
    reset8 = 1'b0;
    tick();
    checks++;
    if (data8 !== 8'hB8) begin
      errors++; $display("FAIL hold_release got=%h want=b8", data8);
    end
  endtask

  task automatic test_width16();
    logic [15:0] exp16 [0:3];
    exp16 = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00};
    seed16 = 16'h0001; reset16 = 1'b1;
    tick();
    checks++;
    if (data16 !== exp16[0]) begin
      errors++; $display("FAIL w16_load got=%h want=%h", data16, exp16[0]);
    end
    reset16 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (data16 !== exp16[i]) begin
        errors++; $display("FAIL w16_step%0d got=%h want=%h", i, data16, exp16[i]);
      end
    end
  endtask

  initial begin
    reset8  = 1'b0;
    seed8   = 8'h00;
    reset16 = 1'b0;
    seed16  = 16'h0000;
    #2;
    test_reset();
    test_zero_seed();
    test_period();
    test_seed_ignored();
    test_hold_reset();
    test_width16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
